// File: rtl/lse_lut_loader.sv
// -----------------------------------------------------------------------------
// lse_lut_loader
//
// Writer side of the LSE correction-LUT interface. It takes a valid/ready
// stream of packed LUT words from the host/config path and fills the
// lut_table register array. Every einsum_add instance reads that array
// combinationally. table_valid flags a table that is completely and
// consistently loaded since the last start, abort or reset.
//
// Parameters
//   LUT_SIZE       number of table entries
//   LUT_PRECISION  bits per table entry
//   WORD_WIDTH     input stream word width
//   EPW (local)    entries packed per word = WORD_WIDTH / LUT_PRECISION
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset (also zeroes the table)
//   load_start   one-cycle request to begin a full-table load (IDLE only)
//   load_abort   abandon an in-progress load (LOAD only)
//   in_valid     input word valid
//   in_data      packed entries; slot s at [s*LUT_PRECISION +: LUT_PRECISION]
//   in_ready     high in LOAD; a decode of state only
//   busy         load in progress
//   load_done    one-cycle pulse after the final entry is written
//   table_valid  table fully loaded since last start/abort/reset
//   lut_table    correction table consumed by the adders
// -----------------------------------------------------------------------------
module lse_lut_loader #(
  parameter int LUT_SIZE      = 1024,
  parameter int LUT_PRECISION = 10,
  parameter int WORD_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_abort,
  input  logic                     in_valid,
  input  logic [WORD_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     load_done,
  output logic                     table_valid,
  output logic [LUT_PRECISION-1:0] lut_table [LUT_SIZE]
);

  localparam int EPW    = WORD_WIDTH / LUT_PRECISION;
  localparam int IDX_W  = $clog2(LUT_SIZE) + 1;
  localparam int ADDR_W = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1;
  // Headroom so idx + EPW can never wrap before the end-of-table compare.
  localparam int SUM_W  = IDX_W + $clog2(EPW + 1) + 1;
  localparam int USED_W = EPW * LUT_PRECISION;
  localparam int NSLOT  = (EPW < 1) ? 1 : EPW;

  generate
    if (EPW < 1) begin : g_epw_chk
      $error("lse_lut_loader: WORD_WIDTH must hold at least one LUT entry");
    end
    // Bits above the last whole slot carry no entry.
    if (USED_W < WORD_WIDTH) begin : g_unused_hi
      logic unused_hi_bits;
      assign unused_hi_bits = ^in_data[WORD_WIDTH-1:USED_W];
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;

  logic             beat_vld_p0;
  logic             last_beat;
  logic [SUM_W-1:0] idx_sum;

  logic [SUM_W-1:0]         slot_pos  [NSLOT];
  logic                     slot_en   [NSLOT];
  logic [ADDR_W-1:0]        slot_addr [NSLOT];
  logic [LUT_PRECISION-1:0] slot_val  [NSLOT];

  function automatic logic [LUT_PRECISION-1:0] slot_of(
    input logic [WORD_WIDTH-1:0] word,
    input int                    s
  );
    return word[s*LUT_PRECISION +: LUT_PRECISION];
  endfunction

  // A slot only lands in the table if its target entry exists.
  function automatic logic slot_in_range(input logic [SUM_W-1:0] pos);
    return pos < SUM_W'(LUT_SIZE);
  endfunction

  // ---------------------------------------------------------------------------
  // Beat decode: accept, end-of-table detection and per-slot targets
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_sum     = SUM_W'(idx) + SUM_W'(EPW);
    last_beat   = (idx_sum >= SUM_W'(LUT_SIZE));
    // Abort wins over a beat presented in the same cycle.
    beat_vld_p0 = in_valid && in_ready && !load_abort;
    for (int s = 0; s < NSLOT; s++) begin
      slot_pos[s]  = SUM_W'(idx) + SUM_W'(s);
      slot_en[s]   = slot_in_range(slot_pos[s]);
      slot_addr[s] = ADDR_W'(slot_pos[s]);
      slot_val[s]  = slot_of(in_data, s);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // Start wins over a simultaneous abort; abort alone is ignored here.
        if (load_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (load_abort)                state_nxt = S_IDLE;
        else if (in_valid && last_beat) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs (state decode only, never a function of in_valid)
  always_comb begin
    busy     = (state == S_LOAD);
    in_ready = (state == S_LOAD);
  end

  // ---------------------------------------------------------------------------
  // Write pointer, completion pulse and table-valid flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      load_done   <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      load_done <= beat_vld_p0 && last_beat;
      if (state == S_IDLE && load_start) begin
        idx         <= '0;
        table_valid <= 1'b0;
      end else if (beat_vld_p0) begin
        idx <= IDX_W'(idx_sum);
        if (last_beat) table_valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Table storage: accepted slots become visible right after the edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LUT_SIZE; i++) begin
        lut_table[i] <= '0;
      end
    end else if (beat_vld_p0) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (slot_en[s]) lut_table[slot_addr[s]] <= slot_val[s];
      end
    end
  end

endmodule

// File: tb/tb_lse_lut_loader.sv
// -----------------------------------------------------------------------------
// tb_lse_lut_loader
//
// Directed bench for lse_lut_loader. A small instance (LUT_SIZE=8, EPW=3)
// carries the protocol corner cases; a default-sized instance covers reset
// and a full 1024-entry load.
// -----------------------------------------------------------------------------
module tb_lse_lut_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Small instance
  logic        s_start, s_abort, s_valid;
  logic [31:0] s_data;
  logic        s_ready, s_busy, s_done, s_tv;
  logic [9:0]  s_tab [8];

  // Default-size instance
  logic        b_start, b_abort, b_valid;
  logic [31:0] b_data;
  logic        b_ready, b_busy, b_done, b_tv;
  logic [9:0]  b_tab [1024];

  lse_lut_loader #(.LUT_SIZE(8), .LUT_PRECISION(10), .WORD_WIDTH(32)) u_small (
    .clk(clk), .rst(rst), .load_start(s_start), .load_abort(s_abort),
    .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready), .busy(s_busy),
    .load_done(s_done), .table_valid(s_tv), .lut_table(s_tab)
  );

  lse_lut_loader u_big (
    .clk(clk), .rst(rst), .load_start(b_start), .load_abort(b_abort),
    .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready), .busy(b_busy),
    .load_done(b_done), .table_valid(b_tv), .lut_table(b_tab)
  );

  int total = 0;
  int bad   = 0;
  int s_done_cnt = 0;
  int b_done_cnt = 0;

  always @(posedge clk) begin
    if (s_done) s_done_cnt <= s_done_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
  end

  typedef struct {
    logic [31:0]      data;
    int               n;        // slots that land in the table
    logic [2:0][9:0]  e;        // expected entries, e[0] = slot 0
    logic             busy_after;
    logic             done_after;
  } vec_t;

  vec_t       vecs [3];
  logic [9:0] exp_full [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
    return {2'b00, c, b, a};
  endfunction

  function automatic logic [9:0] big_val(input int i);
    return 10'(i) ^ 10'h155;
  endfunction

  task automatic s_start_load;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  task automatic s_beat(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic chk_small_full(input string tag);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_e%0d", tag, k), 32'(s_tab[k]), 32'(exp_full[k]));
  endtask

  task automatic async_reset_pulse;
    #3 rst = 1'b1;
    #1;
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  int d0;
  int gap;

  initial begin
    vecs[0] = '{32'h00302001, 3, {10'd3,  10'd8,  10'd1}, 1'b1, 1'b0};
    vecs[1] = '{32'h00705006, 3, {10'd7,  10'd20, 10'd6}, 1'b1, 1'b0};
    vecs[2] = '{32'h3FF0A009, 2, {10'h3FF, 10'd40, 10'd9}, 1'b0, 1'b1};
    exp_full = '{10'd1, 10'd8, 10'd3, 10'd6, 10'd20, 10'd7, 10'd9, 10'd40};

    rst = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; s_valid = 1'b0; s_data = '0;
    b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_data = '0;
    tick();
    tick();
    chk("rst_s_busy",  32'(s_busy),  32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_s_done",  32'(s_done),  32'd0);
    chk("rst_s_tv",    32'(s_tv),    32'd0);
    chk("rst_b_busy",  32'(b_busy),  32'd0);
    chk("rst_b_tab0",  32'(b_tab[0]), 32'd0);
    rst = 1'b0;
    tick();

    // ---- continuous full load, table-driven --------------------------------
    s_start_load();
    chk("start_busy",  32'(s_busy),  32'd1);
    chk("start_ready", 32'(s_ready), 32'd1);
    chk("start_tv",    32'(s_tv),    32'd0);
    d0 = s_done_cnt;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = vecs[i].data;
      tick();
      for (int k = 0; k < vecs[i].n; k++)
        chk($sformatf("cont_b%0d_e%0d", i, 3*i + k), 32'(s_tab[3*i + k]), 32'(vecs[i].e[k]));
      chk($sformatf("cont_b%0d_busy", i), 32'(s_busy), 32'(vecs[i].busy_after));
      chk($sformatf("cont_b%0d_done", i), 32'(s_done), 32'(vecs[i].done_after));
    end
    s_valid = 1'b0;
    chk("cont_tv_at_done", 32'(s_tv), 32'd1);
    tick();
    chk("cont_done_pulse_end", 32'(s_done), 32'd0);
    chk("cont_done_count", 32'(s_done_cnt - d0), 32'd1);
    chk("cont_tv", 32'(s_tv), 32'd1);
    chk_small_full("cont");

    // ---- full default-size load: 342 beats --------------------------------
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    d0 = b_done_cnt;
    for (int b = 0; b < 342; b++) begin
      b_valid = 1'b1;
      b_data  = pack3(big_val(3*b), big_val(3*b + 1), big_val(3*b + 2));
      tick();
      if (b == 340) chk("big_busy_before_last", 32'(b_busy), 32'd1);
    end
    b_valid = 1'b0;
    tick();
    chk("big_done_count", 32'(b_done_cnt - d0), 32'd1);
    chk("big_tv",     32'(b_tv),     32'd1);
    chk("big_busy",   32'(b_busy),   32'd0);
    chk("big_e0",     32'(b_tab[0]),    32'h155);
    chk("big_e500",   32'(b_tab[500]),  32'(big_val(500)));
    chk("big_e1022",  32'(b_tab[1022]), 32'(big_val(1022)));
    chk("big_e1023",  32'(b_tab[1023]), 32'h2AA);

    // ---- asynchronous reset mid-cycle -------------------------------------
    async_reset_pulse();
    chk("arst_s_busy",  32'(s_busy),  32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    chk("arst_s_tv",    32'(s_tv),    32'd0);
    chk("arst_s_e1",    32'(s_tab[1]), 32'd0);
    chk("arst_s_e7",    32'(s_tab[7]), 32'd0);
    chk("arst_b_tv",    32'(b_tv),    32'd0);
    chk("arst_b_e0",    32'(b_tab[0]),    32'd0);
    chk("arst_b_e1023", 32'(b_tab[1023]), 32'd0);
    release_reset();

    // ---- backpressure / stalls --------------------------------------------
    s_start_load();
    d0 = s_done_cnt;
    for (int i = 0; i < 3; i++) begin
      gap = int'($urandom_range(5, 0));
      if (i == 1) gap = 5;
      repeat (gap) begin
        s_valid = 1'b0;
        tick();
        chk($sformatf("stall_b%0d_gap_done", i), 32'(s_done), 32'd0);
      end
      s_beat(vecs[i].data);
      chk($sformatf("stall_b%0d_done", i), 32'(s_done), 32'(vecs[i].done_after));
    end
    tick();
    chk("stall_done_count", 32'(s_done_cnt - d0), 32'd1);
    chk("stall_tv", 32'(s_tv), 32'd1);
    chk_small_full("stall");

    // ---- abort after beat 1 with beat 2 presented --------------------------
    d0 = s_done_cnt;
    s_start_load();
    s_beat(pack3(10'd100, 10'd200, 10'd300));
    chk("abort_busy_mid", 32'(s_busy), 32'd1);
    s_valid = 1'b1;
    s_data  = pack3(10'd400, 10'd500, 10'd600);
    s_abort = 1'b1;
    tick();
    s_valid = 1'b0;
    s_abort = 1'b0;
    chk("abort_busy",  32'(s_busy),  32'd0);
    chk("abort_ready", 32'(s_ready), 32'd0);
    chk("abort_tv",    32'(s_tv),    32'd0);
    chk("abort_e0", 32'(s_tab[0]), 32'd100);
    chk("abort_e2", 32'(s_tab[2]), 32'd300);
    chk("abort_e3", 32'(s_tab[3]), 32'd6);
    chk("abort_e4", 32'(s_tab[4]), 32'd20);
    chk("abort_e5", 32'(s_tab[5]), 32'd7);
    tick();
    chk("abort_no_done", 32'(s_done_cnt - d0), 32'd0);

    // ---- ignored controls in IDLE -----------------------------------------
    s_valid = 1'b1;
    s_data  = 32'hFFFF_FFFF;
    s_abort = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;
    s_abort = 1'b0;
    chk("idle_busy", 32'(s_busy), 32'd0);
    chk("idle_e0",   32'(s_tab[0]), 32'd100);
    chk("idle_e3",   32'(s_tab[3]), 32'd6);
    chk("idle_e7",   32'(s_tab[7]), 32'd40);

    // ---- load_start during LOAD is ignored; beat count unaffected ---------
    d0 = s_done_cnt;
    s_start_load();
    s_beat(pack3(10'd11, 10'd12, 10'd13));
    s_start = 1'b1;
    s_beat(pack3(10'd14, 10'd15, 10'd16));
    s_start = 1'b0;
    chk("ign_busy_b2", 32'(s_busy), 32'd1);
    chk("ign_e0", 32'(s_tab[0]), 32'd11);
    chk("ign_e3", 32'(s_tab[3]), 32'd14);
    s_beat(pack3(10'd17, 10'd18, 10'd19));
    chk("ign_done", 32'(s_done), 32'd1);
    chk("ign_tv",   32'(s_tv),   32'd1);
    chk("ign_e6",   32'(s_tab[6]), 32'd17);
    chk("ign_e7",   32'(s_tab[7]), 32'd18);

    // ---- back-to-back start in the done cycle, start beats abort ----------
    s_start = 1'b1;
    s_abort = 1'b1;
    tick();
    s_start = 1'b0;
    s_abort = 1'b0;
    chk("b2b_busy", 32'(s_busy), 32'd1);
    chk("b2b_tv",   32'(s_tv),   32'd0);
    chk("b2b_done_count", 32'(s_done_cnt - d0), 32'd1);

    // ---- reset mid-load, then a fresh load needs 3 beats -------------------
    s_beat(pack3(10'd21, 10'd22, 10'd23));
    s_beat(pack3(10'd24, 10'd25, 10'd26));
    chk("mrst_pre_busy", 32'(s_busy), 32'd1);
    chk("mrst_pre_e4",   32'(s_tab[4]), 32'd25);
    async_reset_pulse();
    chk("mrst_busy", 32'(s_busy), 32'd0);
    chk("mrst_tv",   32'(s_tv),   32'd0);
    chk("mrst_e0",   32'(s_tab[0]), 32'd0);
    chk("mrst_e4",   32'(s_tab[4]), 32'd0);
    chk("mrst_e7",   32'(s_tab[7]), 32'd0);
    release_reset();
    chk("mrst_idle_busy", 32'(s_busy), 32'd0);
    s_start_load();
    s_beat(vecs[0].data);
    s_beat(vecs[1].data);
    chk("fresh_b2_done", 32'(s_done), 32'd0);
    chk("fresh_b2_busy", 32'(s_busy), 32'd1);
    s_beat(vecs[2].data);
    chk("fresh_b3_done", 32'(s_done), 32'd1);
    tick();
    chk("fresh_tv", 32'(s_tv), 32'd1);
    chk_small_full("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
